// File: rtl/hazard_stall_controller_pkg.sv
// Shared encodings for the pipeline hazard/stall sequencer.
package hazard_stall_controller_pkg;

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_MD_WAIT = 1'b1
  } state_t;

  localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/hazard_stall_controller_if.sv
// Pipeline-side hazard sources and stage stall/flush controls.
interface hazard_stall_controller_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       ID_rs1;
  logic [4:0]       ID_rs2;
  logic             ID_Use_rs1;
  logic             ID_Use_rs2;
  logic             EX_Mem_Read;
  logic             EX_Write_Enable;
  logic [4:0]       EX_WriteAddress;
  logic             EX_Redirect;
  logic             EX_MulDiv_Start;
  logic             MulDiv_Done;
  logic             PC_Stall;
  logic             IF_ID_Stall;
  logic             IF_ID_Flush;
  logic             ID_EX_Stall;
  logic             ID_EX_Flush;
  logic             EX_MEM_Flush;
  logic             MulDiv_Timeout;
  logic [CNT_W-1:0] Stall_Count;

  modport master (
    output ID_rs1, ID_rs2, ID_Use_rs1, ID_Use_rs2, EX_Mem_Read, EX_Write_Enable,
           EX_WriteAddress, EX_Redirect, EX_MulDiv_Start, MulDiv_Done,
    input  PC_Stall, IF_ID_Stall, IF_ID_Flush, ID_EX_Stall, ID_EX_Flush,
           EX_MEM_Flush, MulDiv_Timeout, Stall_Count
  );

  modport slave (
    input  ID_rs1, ID_rs2, ID_Use_rs1, ID_Use_rs2, EX_Mem_Read, EX_Write_Enable,
           EX_WriteAddress, EX_Redirect, EX_MulDiv_Start, MulDiv_Done,
    output PC_Stall, IF_ID_Stall, IF_ID_Flush, ID_EX_Stall, ID_EX_Flush,
           EX_MEM_Flush, MulDiv_Timeout, Stall_Count
  );
endinterface

// File: rtl/hazard_stall_controller.sv
// Stall/flush sequencer for the 5-stage core: load-use, EX redirects and multi-cycle M-ops.
// state      | meaning
// ST_RUN     | normal issue; resolve redirect > M-op start > load-use
// ST_MD_WAIT | M-op holds EX; stall front end until done or timeout
module hazard_stall_controller
  import hazard_stall_controller_pkg::*;
#(
  parameter int MD_TIMEOUT = 64,
  parameter int CNT_W      = 32
) (
  input logic                       CLK,
  input logic                       Reset,
  hazard_stall_controller_if.slave  hz
);

  localparam int WAIT_W = $clog2(MD_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MD_TIMEOUT);

  state_t             state_q, state_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [CNT_W-1:0]   stall_cnt_q;
  logic               timeout_q;
  logic               timeout_set;
  logic               load_use;
  logic               pc_stall, if_id_stall, if_id_flush;
  logic               id_ex_stall, id_ex_flush, ex_mem_flush;

  assign load_use = hz.EX_Mem_Read && hz.EX_Write_Enable && (hz.EX_WriteAddress != REG_X0)
                    && ((hz.ID_Use_rs1 && (hz.ID_rs1 == hz.EX_WriteAddress))
                     || (hz.ID_Use_rs2 && (hz.ID_rs2 == hz.EX_WriteAddress)));

  always_comb begin
    state_d      = state_q;
    wait_d       = wait_q;
    timeout_set  = 1'b0;
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_stall  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    if (!Reset) begin
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (hz.EX_Redirect) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
          end else if (hz.EX_MulDiv_Start && !hz.MulDiv_Done) begin
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_stall  = 1'b1;
            ex_mem_flush = 1'b1;
            state_d      = ST_MD_WAIT;
            wait_d       = WAIT_W'(1);
          end else if (load_use) begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            id_ex_flush = 1'b1;
          end
        end
        ST_MD_WAIT: begin
          // EX is occupied by the M-op, so redirect and load-use cannot apply here
          if (hz.MulDiv_Done) begin
            state_d = ST_RUN;
            wait_d  = '0;
          end else if (wait_q < WAIT_LIMIT) begin
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_stall  = 1'b1;
            ex_mem_flush = 1'b1;
            wait_d       = wait_q + 1'b1;
          end else begin
            timeout_set = 1'b1;
            state_d     = ST_RUN;
            wait_d      = '0;
          end
        end
        default: begin
          state_d = ST_RUN;
          wait_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!Reset) begin
      state_q     <= ST_RUN;
      wait_q      <= '0;
      stall_cnt_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (timeout_set) timeout_q <= 1'b1;
      if (pc_stall && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign hz.PC_Stall       = pc_stall;
  assign hz.IF_ID_Stall    = if_id_stall;
  assign hz.IF_ID_Flush    = if_id_flush;
  assign hz.ID_EX_Stall    = id_ex_stall;
  assign hz.ID_EX_Flush    = id_ex_flush;
  assign hz.EX_MEM_Flush   = ex_mem_flush;
  assign hz.MulDiv_Timeout = timeout_q;
  assign hz.Stall_Count    = stall_cnt_q;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed bench: instance A uses default timeout; instance B uses MD_TIMEOUT=4, CNT_W=3.
module tb_hazard_stall_controller;
  import hazard_stall_controller_pkg::*;

  logic CLK = 1'b0;
  logic Reset;
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  always #5 CLK = ~CLK;

  hazard_stall_controller_if #(.CNT_W(32)) hif_a ();
  hazard_stall_controller_if #(.CNT_W(3))  hif_b ();

  hazard_stall_controller #(.MD_TIMEOUT(64), .CNT_W(32)) dut_a (.CLK(CLK), .Reset(Reset), .hz(hif_a));
  hazard_stall_controller #(.MD_TIMEOUT(4),  .CNT_W(3))  dut_b (.CLK(CLK), .Reset(Reset), .hz(hif_b));

  // Output vector order: PC_Stall, IF_ID_Stall, IF_ID_Flush, ID_EX_Stall, ID_EX_Flush, EX_MEM_Flush
  localparam logic [5:0] O_NONE  = 6'b000000;
  localparam logic [5:0] O_RST   = 6'b001011;
  localparam logic [5:0] O_LU    = 6'b110010;
  localparam logic [5:0] O_REDIR = 6'b001010;
  localparam logic [5:0] O_MD    = 6'b110101;

  function automatic logic [5:0] outs_a();
    return {hif_a.PC_Stall, hif_a.IF_ID_Stall, hif_a.IF_ID_Flush,
            hif_a.ID_EX_Stall, hif_a.ID_EX_Flush, hif_a.EX_MEM_Flush};
  endfunction

  function automatic logic [5:0] outs_b();
    return {hif_b.PC_Stall, hif_b.IF_ID_Stall, hif_b.IF_ID_Flush,
            hif_b.ID_EX_Stall, hif_b.ID_EX_Flush, hif_b.EX_MEM_Flush};
  endfunction

  task automatic set_a(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1, input logic u2,
                       input logic mr, input logic we, input logic [4:0] wa,
                       input logic redir, input logic start, input logic done);
    hif_a.ID_rs1 = rs1; hif_a.ID_rs2 = rs2; hif_a.ID_Use_rs1 = u1; hif_a.ID_Use_rs2 = u2;
    hif_a.EX_Mem_Read = mr; hif_a.EX_Write_Enable = we; hif_a.EX_WriteAddress = wa;
    hif_a.EX_Redirect = redir; hif_a.EX_MulDiv_Start = start; hif_a.MulDiv_Done = done;
  endtask

  task automatic set_b(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1, input logic u2,
                       input logic mr, input logic we, input logic [4:0] wa,
                       input logic redir, input logic start, input logic done);
    hif_b.ID_rs1 = rs1; hif_b.ID_rs2 = rs2; hif_b.ID_Use_rs1 = u1; hif_b.ID_Use_rs2 = u2;
    hif_b.EX_Mem_Read = mr; hif_b.EX_Write_Enable = we; hif_b.EX_WriteAddress = wa;
    hif_b.EX_Redirect = redir; hif_b.EX_MulDiv_Start = start; hif_b.MulDiv_Done = done;
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    set_a(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    set_b(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge CLK); #1;
    total_cnt++;
    if (outs_a() !== O_RST) $display("FAIL reset_outs: got %b want %b", outs_a(), O_RST);
    else pass_cnt++;
    @(negedge CLK);
    total_cnt++;
    if (hif_a.Stall_Count !== 32'd0 || hif_a.MulDiv_Timeout !== 1'b0 || dut_a.state_q !== ST_RUN)
      $display("FAIL reset_regs: cnt=%0d to=%b st=%b want 0 0 0",
               hif_a.Stall_Count, hif_a.MulDiv_Timeout, dut_a.state_q);
    else pass_cnt++;
    Reset = 1'b1;
  endtask

  task automatic test_load_use();
    logic [31:0] base;
    base = hif_a.Stall_Count;
    // lw x5 in EX, add x6,x5,x7 in ID
    set_a(5, 7, 1, 1, 1, 1, 5, 0, 0, 0);
    #1;
    total_cnt++;
    if (outs_a() !== O_LU) $display("FAIL load_use_rs1: got %b want %b", outs_a(), O_LU);
    else pass_cnt++;
    @(negedge CLK);
    set_a(5, 7, 1, 1, 0, 0, 0, 0, 0, 0);
    #1;
    total_cnt++;
    if (outs_a() !== O_NONE) $display("FAIL load_use_release: got %b want %b", outs_a(), O_NONE);
    else pass_cnt++;
    @(negedge CLK);
    total_cnt++;
    if (hif_a.Stall_Count !== base + 32'd1)
      $display("FAIL load_use_count: got %0d want %0d", hif_a.Stall_Count, base + 32'd1);
    else pass_cnt++;
    set_a(3, 5, 1, 1, 1, 1, 5, 0, 0, 0);
    #1;
    total_cnt++;
    if (outs_a() !== O_LU) $display("FAIL load_use_rs2: got %b want %b", outs_a(), O_LU);
    else pass_cnt++;
    @(negedge CLK);
    set_a(3, 5, 1, 0, 1, 1, 5, 0, 0, 0);
    #1;
    total_cnt++;
    if (outs_a() !== O_NONE) $display("FAIL load_use_rs2_unused: got %b want %b", outs_a(), O_NONE);
    else pass_cnt++;
    @(negedge CLK);
    set_a(0, 7, 1, 1, 1, 1, 0, 0, 0, 0);
    #1;
    total_cnt++;
    if (outs_a() !== O_NONE) $display("FAIL load_use_x0: got %b want %b", outs_a(), O_NONE);
    else pass_cnt++;
    @(negedge CLK);
    set_a(5, 7, 1, 1, 1, 0, 5, 0, 0, 0);
    #1;
    total_cnt++;
    if (outs_a() !== O_NONE) $display("FAIL load_use_no_we: got %b want %b", outs_a(), O_NONE);
    else pass_cnt++;
    @(negedge CLK);
    set_a(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    total_cnt++;
    if (hif_a.Stall_Count !== base + 32'd2)
      $display("FAIL load_use_count2: got %0d want %0d", hif_a.Stall_Count, base + 32'd2);
    else pass_cnt++;
  endtask

  task automatic test_redirect();
    logic [31:0] base;
    base = hif_a.Stall_Count;
    set_a(5, 7, 1, 1, 1, 1, 5, 1, 0, 0);
    #1;
    total_cnt++;
    if (outs_a() !== O_REDIR) $display("FAIL redirect_outs: got %b want %b", outs_a(), O_REDIR);
    else pass_cnt++;
    @(negedge CLK);
    set_a(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    total_cnt++;
    if (hif_a.Stall_Count !== base)
      $display("FAIL redirect_count: got %0d want %0d", hif_a.Stall_Count, base);
    else pass_cnt++;
  endtask

  task automatic test_muldiv_wait();
    logic [31:0] base;
    base = hif_a.Stall_Count;
    for (int i = 0; i < 5; i++) begin
      // hazard sources during the wait must not change the stall pattern
      if (i == 2) set_a(5, 7, 1, 1, 1, 1, 5, 1, 1, 0);
      else        set_a(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      #1;
      total_cnt++;
      if (outs_a() !== O_MD) $display("FAIL muldiv_stall[%0d]: got %b want %b", i, outs_a(), O_MD);
      else pass_cnt++;
      @(negedge CLK);
    end
    set_a(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    #1;
    total_cnt++;
    if (outs_a() !== O_NONE) $display("FAIL muldiv_done_outs: got %b want %b", outs_a(), O_NONE);
    else pass_cnt++;
    @(negedge CLK);
    set_a(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    total_cnt++;
    if (hif_a.Stall_Count !== base + 32'd5 || dut_a.state_q !== ST_RUN || hif_a.MulDiv_Timeout !== 1'b0)
      $display("FAIL muldiv_after: cnt=%0d st=%b to=%b want %0d 0 0",
               hif_a.Stall_Count, dut_a.state_q, hif_a.MulDiv_Timeout, base + 32'd5);
    else pass_cnt++;
  endtask

  task automatic test_single_mul();
    logic [31:0] base;
    base = hif_a.Stall_Count;
    set_a(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    #1;
    total_cnt++;
    if (outs_a() !== O_NONE) $display("FAIL single_mul_outs: got %b want %b", outs_a(), O_NONE);
    else pass_cnt++;
    @(negedge CLK);
    set_a(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    total_cnt++;
    if (dut_a.state_q !== ST_RUN || hif_a.Stall_Count !== base)
      $display("FAIL single_mul_state: st=%b cnt=%0d want 0 %0d", dut_a.state_q, hif_a.Stall_Count, base);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_md();
    set_a(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    @(negedge CLK);
    @(negedge CLK);
    total_cnt++;
    if (dut_a.state_q !== ST_MD_WAIT)
      $display("FAIL mid_md_entered: got %b want %b", dut_a.state_q, ST_MD_WAIT);
    else pass_cnt++;
    Reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      total_cnt++;
      if (outs_a() !== O_RST) $display("FAIL mid_md_reset_outs[%0d]: got %b want %b", i, outs_a(), O_RST);
      else pass_cnt++;
      @(negedge CLK);
    end
    total_cnt++;
    if (dut_a.state_q !== ST_RUN || dut_a.wait_q !== '0 || hif_a.Stall_Count !== 32'd0)
      $display("FAIL mid_md_reset_regs: st=%b wait=%0d cnt=%0d want 0 0 0",
               dut_a.state_q, dut_a.wait_q, hif_a.Stall_Count);
    else pass_cnt++;
    set_a(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    Reset = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_timeout();
    for (int i = 0; i < 4; i++) begin
      set_b(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      #1;
      total_cnt++;
      if (outs_b() !== O_MD) $display("FAIL timeout_stall[%0d]: got %b want %b", i, outs_b(), O_MD);
      else pass_cnt++;
      @(negedge CLK);
    end
    #1;
    total_cnt++;
    if (outs_b() !== O_NONE) $display("FAIL timeout_release: got %b want %b", outs_b(), O_NONE);
    else pass_cnt++;
    @(negedge CLK);
    set_b(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    total_cnt++;
    if (hif_b.MulDiv_Timeout !== 1'b1 || dut_b.state_q !== ST_RUN || hif_b.Stall_Count !== 3'd4)
      $display("FAIL timeout_after: to=%b st=%b cnt=%0d want 1 0 4",
               hif_b.MulDiv_Timeout, dut_b.state_q, hif_b.Stall_Count);
    else pass_cnt++;
    @(negedge CLK);
    @(negedge CLK);
    total_cnt++;
    if (hif_b.MulDiv_Timeout !== 1'b1) $display("FAIL timeout_sticky: got %b want 1", hif_b.MulDiv_Timeout);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back_saturate();
    for (int i = 0; i < 4; i++) begin
      set_b(9, 0, 1, 0, 1, 1, 9, 0, 0, 0);
      #1;
      total_cnt++;
      if (outs_b() !== O_LU) $display("FAIL sat_stall[%0d]: got %b want %b", i, outs_b(), O_LU);
      else pass_cnt++;
      @(negedge CLK);
    end
    set_b(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    total_cnt++;
    if (hif_b.Stall_Count !== 3'd7) $display("FAIL sat_count: got %0d want 7", hif_b.Stall_Count);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    @(negedge CLK);
    test_load_use();
    test_redirect();
    test_muldiv_wait();
    test_single_mul();
    test_reset_mid_md();
    test_timeout();
    test_back_to_back_saturate();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
